// File: rtl/apb_rmw_pkg.sv
// Shared types for the APB read/write/read-increment-write master.
// The optional ACCESS timeout is enabled with the APB_RMW_TIMEOUT_EN macro.
package apb_rmw_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_RD  = 2'b01,
    OP_WR  = 2'b10,
    OP_RMW = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  // Phase bit: it also drives PWRITE while a transfer is in progress.
  localparam logic PH_READ  = 1'b0;
  localparam logic PH_WRITE = 1'b1;

endpackage

// File: rtl/apb_timeout_ctr.sv
// ACCESS-phase wait counter; only compiled when APB_RMW_TIMEOUT_EN is defined.
// o_expired is high during the TIMEOUT_CYCLES-th counted cycle.
`ifdef APB_RMW_TIMEOUT_EN
module apb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired = (r_cnt == LAST);

endmodule
`endif

// File: rtl/apb_rmw_master.sv
// APB3 master accepting read, write and read-increment-write commands, one response each.
// Define APB_RMW_TIMEOUT_EN to bound the ACCESS phase to TIMEOUT_CYCLES wait cycles.
module apb_rmw_master
  import apb_rmw_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int INC_VAL        = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic              pready_i,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pslverr_i,
  output logic [1:0]        dbg_state_o
);

  localparam logic [DATA_W-1:0] INC_W = DATA_W'(INC_VAL);

  // Command handshake: a command moves when cmd_valid_i and cmd_ready_o are both
  // high on a rising edge; cmd_ready_o is high exactly while the FSM is IDLE.
  state_e            r_state, w_next;
  op_e               r_op;
  logic              r_phase;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata, r_rdata;
  logic              r_rsp_valid, r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;

  op_e               w_cmd_op;
  logic              w_accept, w_xfer_done, w_rmw_continue, w_timeout;
  logic              w_rsp_fire, w_rsp_err;
  logic [DATA_W-1:0] w_rsp_rdata;

  assign w_cmd_op       = op_e'(cmd_op_i);
  assign w_accept       = cmd_valid_i && (r_state == ST_IDLE);
  assign w_xfer_done    = (r_state == ST_ACCESS) && pready_i;
  assign w_rmw_continue = w_xfer_done && (r_op == OP_RMW) && (r_phase == PH_READ) && !pslverr_i;

`ifdef APB_RMW_TIMEOUT_EN
  logic w_expired;

  apb_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (r_state == ST_SETUP),
    .i_enable (r_state == ST_ACCESS),
    .o_expired(w_expired)
  );

  assign w_timeout = w_expired && (r_state == ST_ACCESS) && !pready_i;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept && (w_cmd_op != OP_NOP)) w_next = ST_SETUP;
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: begin
        if (w_rmw_continue)               w_next = ST_SETUP;
        else if (pready_i || w_timeout)   w_next = ST_IDLE;
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  // RMW write phase returns the value captured in the read phase; a read completion reports live data.
  always_comb begin
    w_rsp_fire  = (w_accept && (w_cmd_op == OP_NOP)) || (w_xfer_done && !w_rmw_continue) || w_timeout;
    w_rsp_err   = (w_xfer_done && pslverr_i) || w_timeout;
    w_rsp_rdata = '0;
    if (w_xfer_done) begin
      if (r_phase == PH_READ)  w_rsp_rdata = prdata_i;
      else if (r_op == OP_RMW) w_rsp_rdata = r_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op        <= OP_NOP;
      r_phase     <= PH_READ;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_rsp_fire;
      r_rsp_err   <= w_rsp_fire && w_rsp_err;
      r_rsp_rdata <= w_rsp_fire ? w_rsp_rdata : '0;
      if (w_accept && (w_cmd_op != OP_NOP)) begin
        r_op    <= w_cmd_op;
        r_paddr <= cmd_addr_i;
        r_phase <= (w_cmd_op == OP_WR) ? PH_WRITE : PH_READ;
        if (w_cmd_op == OP_WR) r_pwdata <= cmd_wdata_i;
      end
      if (w_xfer_done && (r_phase == PH_READ)) r_rdata <= prdata_i;
      if (w_rmw_continue) begin
        r_phase  <= PH_WRITE;
        r_pwdata <= prdata_i + INC_W;
      end
    end
  end

  assign cmd_ready_o = (r_state == ST_IDLE);
  assign psel_o      = (r_state != ST_IDLE);
  assign penable_o   = (r_state == ST_ACCESS);
  assign pwrite_o    = psel_o && (r_phase == PH_WRITE);
  assign paddr_o     = r_paddr;
  assign pwdata_o    = r_pwdata;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;
  assign dbg_state_o = r_state;

endmodule
